proc_1_mem_block_copier: RTL and testbench
==========================================

Name: proc_1_mem_block_copier

Overview:
- Avalon-MM master (initiator) that copies a block of 32-bit words between word addresses of the 10000-word on-chip image memory, optionally inverting each pixel word.
- Drives the memory's s1/s2 slave port from the processing side: one word per read-then-write transaction pair, with no pipelining.
- Controlled by a start/length/address command from the NIOS-side control logic. Reports busy, a done pulse and a bounds error.

Parameters:
- MEM_DEPTH, 10000, number of 32-bit words in the target memory; used for the bounds check.
- ADDR_W, 14, word-address width.
- READ_LATENCY, 1, cycles from read acceptance to valid readdata (1..4).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  command strobe, sampled only in IDLE.
- src_addr  in  ADDR_W  first source word address.
- dst_addr  in  ADDR_W  first destination word address.
- length  in  ADDR_W  words to copy (0 allowed).
- invert  in  1  when 1, writedata = ~readdata; latched at start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  bounds violation on the last command.
- avm_address  out  ADDR_W  word address.
- avm_chipselect  out  1  asserted with read or write.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_byteenable  out  4  always 4'hF during write, else 4'h0.
- avm_writedata  out  32  write data.
- avm_readdata  in  32  read data.
- avm_waitrequest  in  1  slave stall; tie 0 for direct memory attach.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state=IDLE. busy, done, error, avm_read, avm_write, avm_chipselect=0. avm_byteenable=0, avm_address=0, avm_writedata=0.
- Reset mid-transfer aborts immediately. Strobes are low from the cycle after the reset edge. No done pulse is issued.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN.
- IDLE, start=1 at edge k:
  - Latch src, dst, length and invert; clear the word index i and clear error.
  - Bounds check uses 15-bit sums. If src+length>MEM_DEPTH or dst+length>MEM_DEPTH: set error=1, go to FIN with no bus activity.
  - Else if length=0: go to FIN with no bus activity.
  - Else go to RD_REQ, so busy=1 from cycle k+1.
- RD_REQ:
  - Drive avm_read=1, avm_chipselect=1, avm_address=src+i.
  - Hold all outputs stable while avm_waitrequest=1.
  - On an edge with waitrequest=0, go to RD_WAIT with latency counter=READ_LATENCY.
- RD_WAIT:
  - All strobes low; decrement the counter each cycle.
  - Capture avm_readdata (inverted if invert) on the edge that ends the READ_LATENCY-th cycle after the accept cycle, then go to WR_REQ.
- WR_REQ:
  - Drive avm_write=1, avm_chipselect=1, avm_byteenable=4'hF, avm_address=dst+i, avm_writedata=captured word.
  - Hold while waitrequest=1.
  - On acceptance, increment i. If i==length go to FIN, else go to RD_REQ.
- FIN: done=1 for exactly one cycle, busy=0, then return to IDLE.
- error holds its value until the next accepted start.
- start while busy or in FIN is ignored (not queued).
- Per-word cost with no stalls is 2+READ_LATENCY cycles.
- Overlapping ranges copy in ascending order. With dst>src and overlap, the copy deliberately smears forward; the block does no memmove correction.
- avm_read and avm_write are never asserted in the same cycle.
- Address sums never exceed MEM_DEPTH-1 because of the bounds check; no wrap-around occurs.

Test Plan:
- Basic copy: mem[100..103]=1,2,3,4; start with src=100, dst=200, len=4, READ_LATENCY=1, waitrequest=0 at edge 0.
  - Required: busy high in cycles 1..12; done pulse in cycle 13.
  - Required: mem[200..203]=1,2,3,4; exactly 4 reads and 4 writes.
- Stalls: same command with waitrequest=1 for 3 cycles on the first read and 2 cycles on the second write.
  - Required: address, read and write stay stable while stalled; done in cycle 18; data correct.
- Invert: mem[10]=32'h00FF_1234, invert=1, len=1.
  - Required: mem[50]=32'hFF00_EDCB; byteenable=4'hF during the write.
- Length 0 and bounds error:
  - len=0: done one cycle after start, no bus strobes, error=0.
  - src=9998, len=3: done pulse, error=1, no bus strobes.
  - A following valid start clears error.
- Reset mid-transfer: assert reset during RD_WAIT of word 2 of 4.
  - Required: all outputs 0 the next cycle, no done pulse.
  - Required: destination holds only word 1 (or words 1..2 if already written).
- Start while busy: a second start during a transfer is ignored.
  - Required: only the original command executes; exactly one done pulse.

Source files
------------

// File: rtl/proc_1_mem_block_copier.sv
// Avalon-MM master that copies a block of 32-bit words inside the image memory,
// one read-then-write pair per word, optionally inverting each pixel word.
module proc_1_mem_block_copier #(
  parameter int MEM_DEPTH    = 10000,
  parameter int ADDR_W       = 14,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              invert,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN} state_t;

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [2:0]        LAT_INIT = 3'(READ_LATENCY);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  function automatic logic [31:0] pixel_word(input logic [31:0] w, input logic inv);
    return inv ? ~w : w;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d, idx_q, idx_d;
  logic              inv_q, inv_d;
  logic [2:0]        lat_q, lat_d;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic              rd_q, rd_d, wr_q, wr_d, cs_q, cs_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  // Bounds sums carry one extra bit so the compare never wraps.
  logic [ADDR_W:0]   src_end, dst_end;
  logic [ADDR_W-1:0] idx_inc;

  assign src_end = {1'b0, src_addr} + {1'b0, length};
  assign dst_end = {1'b0, dst_addr} + {1'b0, length};
  assign idx_inc = idx_q + ONE;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    inv_d   = inv_q;
    lat_d   = lat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cs_d    = cs_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = length;
          inv_d   = invert;
          idx_d   = '0;
          error_d = 1'b0;
          if (src_end > DEPTH_L || dst_end > DEPTH_L) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = FIN;
          end else if (length == '0) begin
            done_d  = 1'b1;
            state_d = FIN;
          end else begin
            busy_d  = 1'b1;
            rd_d    = 1'b1;
            cs_d    = 1'b1;
            addr_d  = src_addr;
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (!avm_waitrequest) begin
          rd_d    = 1'b0;
          cs_d    = 1'b0;
          lat_d   = LAT_INIT;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_q == 3'd1) begin
          wdata_d = pixel_word(avm_readdata, inv_q);
          wr_d    = 1'b1;
          cs_d    = 1'b1;
          be_d    = 4'hF;
          addr_d  = dst_q + idx_q;
          state_d = WR_REQ;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      WR_REQ: begin
        if (!avm_waitrequest) begin
          wr_d  = 1'b0;
          cs_d  = 1'b0;
          be_d  = 4'h0;
          idx_d = idx_inc;
          if (idx_inc == len_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
          end else begin
            rd_d    = 1'b1;
            cs_d    = 1'b1;
            addr_d  = src_q + idx_inc;
            state_d = RD_REQ;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and bus-facing outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cs_q    <= 1'b0;
      be_q    <= 4'h0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cs_q    <= cs_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Latched command and word index; only meaningful while not IDLE
  always_ff @(posedge clk) begin
    src_q <= src_d;
    dst_q <= dst_d;
    len_q <= len_d;
    idx_q <= idx_d;
    inv_q <= inv_d;
    lat_q <= lat_d;
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_byteenable = be_q;
  assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_proc_1_mem_block_copier.sv
// Scoreboard bench for proc_1_mem_block_copier: a behavioural memory with
// programmable stalls, expected writes and done events queued at issue time.
module tb_proc_1_mem_block_copier;

  localparam int AW = 14;
  localparam logic [31:0] FILL = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          reset, start, invert;
  logic [AW-1:0] src_addr, dst_addr, length;
  logic          busy, done, error;
  logic [AW-1:0] avm_address;
  logic          avm_chipselect, avm_read, avm_write;
  logic [3:0]    avm_byteenable;
  logic [31:0]   avm_writedata;
  logic [31:0]   avm_readdata;
  logic          avm_waitrequest = 1'b0;

  proc_1_mem_block_copier #(.MEM_DEPTH(10000), .ADDR_W(AW), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .invert(invert), .busy(busy), .done(done), .error(error),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_read(avm_read),
    .avm_write(avm_write), .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {logic [AW-1:0] addr; logic [31:0] data;} wr_t;
  typedef struct {logic err; int cyc; int busy_n; int rd_n; int wr_n;} dn_t;

  wr_t   wr_exp[$];
  dn_t   dn_exp[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    cyc = 0;
  logic [31:0] mem [0:9999];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: single-cycle read latency, writes land on the accepting edge.
  always @(posedge clk) begin
    if (avm_chipselect && avm_write && !avm_waitrequest) mem[avm_address] = avm_writedata;
    if (avm_chipselect && avm_read && !avm_waitrequest) avm_readdata <= mem[avm_address];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  int   m_busy = 0, m_rd = 0, m_wr = 0;
  logic stall_prev = 1'b0;
  logic [AW-1:0] sv_addr;
  logic sv_rd, sv_wr;

  // Stall injector: holds waitrequest on the chosen read/write for N cycles.
  int st_rd_idx = 0, st_rd_left = 0, st_wr_idx = 0, st_wr_left = 0;
  always @(posedge clk) begin
    #2;
    if (avm_read && m_rd == st_rd_idx && st_rd_left > 0) begin
      avm_waitrequest = 1'b1;
      st_rd_left--;
    end else if (avm_write && m_wr == st_wr_idx && st_wr_left > 0) begin
      avm_waitrequest = 1'b1;
      st_wr_left--;
    end else begin
      avm_waitrequest = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every accepted write and every done pulse.
  always @(negedge clk) begin
    if (reset) begin
      m_busy = 0; m_rd = 0; m_wr = 0; stall_prev = 1'b0;
    end else begin
      check("rd_wr_exclusive", 32'(avm_read & avm_write), 32'd0);
      if (stall_prev) begin
        check("stall_addr", 32'(avm_address), 32'(sv_addr));
        check("stall_read", 32'(avm_read), 32'(sv_rd));
        check("stall_write", 32'(avm_write), 32'(sv_wr));
      end
      stall_prev = avm_waitrequest && (avm_read || avm_write);
      sv_addr = avm_address; sv_rd = avm_read; sv_wr = avm_write;
      if (busy) m_busy++;
      if (avm_read && !avm_waitrequest) m_rd++;
      if (avm_write && !avm_waitrequest) begin
        m_wr++;
        if (wr_exp.size() == 0) begin
          check("unexpected_write", 32'(avm_address), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = wr_exp.pop_front();
          check("wr_addr", 32'(avm_address), 32'(e.addr));
          check("wr_data", avm_writedata, e.data);
          check("wr_byteenable", 32'(avm_byteenable), 32'hF);
          check("wr_chipselect", 32'(avm_chipselect), 32'd1);
        end
      end
      if (done) begin
        if (dn_exp.size() == 0) begin
          check("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          dn_t d;
          d = dn_exp.pop_front();
          check("done_cycle", 32'(cyc), 32'(d.cyc));
          check("done_error", 32'(error), 32'(d.err));
          check("done_busy_low", 32'(busy), 32'd0);
          check("busy_cycles", 32'(m_busy), 32'(d.busy_n));
          check("read_count", 32'(m_rd), 32'(d.rd_n));
          check("write_count", 32'(m_wr), 32'(d.wr_n));
        end
        m_busy = 0; m_rd = 0; m_wr = 0;
      end
    end
  end

  task automatic issue(input logic [AW-1:0] s, input logic [AW-1:0] d,
                       input logic [AW-1:0] l, input logic inv, output int t0);
    @(negedge clk);
    src_addr = s; dst_addr = d; length = l; invert = inv; start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] v);
    wr_t e;
    e.addr = a; e.data = v;
    wr_exp.push_back(e);
  endtask

  task automatic push_done(input logic err, input int t0, input int k,
                           input int b, input int r, input int w);
    dn_t e;
    e.err = err; e.cyc = t0 + k; e.busy_n = b; e.rd_n = r; e.wr_n = w;
    dn_exp.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (dn_exp.size() == 0 && wr_exp.size() == 0) break;
      @(negedge clk);
    end
    check("drain_pending", 32'(dn_exp.size() + wr_exp.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_read"}, 32'(avm_read), 32'd0);
    check({tag, "_write"}, 32'(avm_write), 32'd0);
    check({tag, "_cs"}, 32'(avm_chipselect), 32'd0);
    check({tag, "_be"}, 32'(avm_byteenable), 32'd0);
    check({tag, "_addr"}, 32'(avm_address), 32'd0);
    check({tag, "_wdata"}, avm_writedata, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    reset = 1'b1; start = 1'b0; invert = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0;
    for (int i = 0; i < 10000; i++) mem[i] = FILL;
    mem[100] = 32'd1; mem[101] = 32'd2; mem[102] = 32'd3; mem[103] = 32'd4;
    mem[10] = 32'h00FF_1234;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Basic 4-word copy
    issue(14'd100, 14'd200, 14'd4, 1'b0, t0);
    push_wr(14'd200, 32'd1); push_wr(14'd201, 32'd2);
    push_wr(14'd202, 32'd3); push_wr(14'd203, 32'd4);
    push_done(1'b0, t0, 13, 12, 4, 4);
    drain();
    check("basic_mem200", mem[200], 32'd1);
    check("basic_mem203", mem[203], 32'd4);

    // Same copy with a 3-cycle read stall and a 2-cycle write stall
    st_rd_idx = 0; st_rd_left = 3; st_wr_idx = 1; st_wr_left = 2;
    issue(14'd100, 14'd300, 14'd4, 1'b0, t0);
    push_wr(14'd300, 32'd1); push_wr(14'd301, 32'd2);
    push_wr(14'd302, 32'd3); push_wr(14'd303, 32'd4);
    push_done(1'b0, t0, 18, 17, 4, 4);
    drain();
    check("stall_mem301", mem[301], 32'd2);
    check("stall_mem303", mem[303], 32'd4);

    // Inverted single word
    issue(14'd10, 14'd50, 14'd1, 1'b1, t0);
    push_wr(14'd50, 32'hFF00_EDCB);
    push_done(1'b0, t0, 4, 3, 1, 1);
    drain();
    check("invert_mem50", mem[50], 32'hFF00_EDCB);

    // Zero length
    issue(14'd20, 14'd30, 14'd0, 1'b0, t0);
    push_done(1'b0, t0, 1, 0, 0, 0);
    drain();

    // Bounds violation on the source range; error must persist
    issue(14'd9998, 14'd0, 14'd3, 1'b0, t0);
    push_done(1'b1, t0, 1, 0, 0, 0);
    drain();
    repeat (3) @(negedge clk);
    check("error_held", 32'(error), 32'd1);
    check("bounds_no_write", mem[0], FILL);

    // A valid start clears the error
    issue(14'd0, 14'd0, 14'd0, 1'b0, t0);
    push_done(1'b0, t0, 1, 0, 0, 0);
    drain();
    check("error_cleared", 32'(error), 32'd0);

    // Second start during a transfer is ignored
    issue(14'd100, 14'd500, 14'd2, 1'b0, t0);
    push_wr(14'd500, 32'd1); push_wr(14'd501, 32'd2);
    push_done(1'b0, t0, 7, 6, 2, 2);
    @(negedge clk);
    src_addr = 14'd10; dst_addr = 14'd600; length = 14'd1; invert = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    check("ignored_mem600", mem[600], FILL);
    check("busy_copy_mem501", mem[501], 32'd2);

    // Reset during RD_WAIT of word 2 of 4
    issue(14'd100, 14'd400, 14'd4, 1'b0, t0);
    push_wr(14'd400, 32'd1);
    for (int i = 0; i < 50 && cyc < t0 + 5; i++) @(negedge clk);
    check("rdwait_busy", 32'(busy), 32'd1);
    check("rdwait_read", 32'(avm_read), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_pending_writes", 32'(wr_exp.size()), 32'd0);
    check("abort_mem400", mem[400], 32'd1);
    check("abort_mem401", mem[401], FILL);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
